// File: rtl/video_timing_gen.sv
// Video timing generator: free-running raster counters with registered sync/DE outputs,
// phase-locked by a vreset pulse. Define VTG_FREERUN_EN to fall back to a free-running raster.
module video_timing_gen #(
  parameter int unsigned H_ACTIVE = 720,
  parameter int unsigned H_FP     = 12,
  parameter int unsigned H_SYNC   = 64,
  parameter int unsigned H_BP     = 68,
  parameter int unsigned V_ACTIVE = 576,
  parameter int unsigned V_FP     = 5,
  parameter int unsigned V_SYNC   = 5,
  parameter int unsigned V_BP     = 39,
  parameter int unsigned RESYNC_H = 0,
  parameter int unsigned RESYNC_V = 0
`ifdef VTG_FREERUN_EN
  ,
  parameter int unsigned FREERUN_FRAMES = 4
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        vreset_i,
  output logic        hs_n_o,
  output logic        vs_n_o,
  output logic        de_o,
  output logic [11:0] hpos_o,
  output logic [10:0] vpos_o,
  output logic        sof_o,
  output logic        locked_o
);

  localparam int unsigned HTotal      = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned VTotal      = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HSyncStart  = H_ACTIVE + H_FP;
  localparam int unsigned VSyncStart  = V_ACTIVE + V_FP;

  // One extra bit so that a window edge equal to the full counter range still compares.
  localparam logic [12:0] HActiveC    = 13'(H_ACTIVE);
  localparam logic [12:0] HSyncStartC = 13'(HSyncStart);
  localparam logic [12:0] HSyncEndC   = 13'(HSyncStart + H_SYNC);
  localparam logic [11:0] HLastC      = 12'(HTotal - 1);
  localparam logic [11:0] HResyncC    = 12'(RESYNC_H);

  localparam logic [11:0] VActiveC    = 12'(V_ACTIVE);
  localparam logic [11:0] VSyncStartC = 12'(VSyncStart);
  localparam logic [11:0] VSyncEndC   = 12'(VSyncStart + V_SYNC);
  localparam logic [10:0] VLastC      = 11'(VTotal - 1);
  localparam logic [10:0] VResyncC    = 11'(RESYNC_V);

  typedef enum logic [1:0] {StWait, StFree, StLocked} state_e;

  state_e      state_q, state_d;
  logic [11:0] hcnt_q, hcnt_d;
  logic [10:0] vcnt_q, vcnt_d;
  logic        line_end, frame_end, freerun_go, run;
  logic [12:0] hcnt_ext;
  logic [11:0] vcnt_ext;

  logic        hs_n_q, hs_n_d;
  logic        vs_n_q, vs_n_d;
  logic        de_q, de_d;
  logic        sof_q, sof_d;
  logic [11:0] hpos_q;
  logic [10:0] vpos_q;

  assign line_end  = (hcnt_q == HLastC);
  assign frame_end = line_end && (vcnt_q == VLastC);
  assign hcnt_ext  = {1'b0, hcnt_q};
  assign vcnt_ext  = {1'b0, vcnt_q};

  // vreset wins over the natural wrap/increment.
  always_comb begin
    hcnt_d = hcnt_q;
    vcnt_d = vcnt_q;
    if (vreset_i) begin
      hcnt_d = HResyncC;
      vcnt_d = VResyncC;
    end else if (line_end) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == VLastC) ? '0 : vcnt_q + 11'd1;
    end else begin
      hcnt_d = hcnt_q + 12'd1;
    end
  end

`ifdef VTG_FREERUN_EN
  localparam int unsigned FrameW = $clog2(FREERUN_FRAMES + 1);

  logic [FrameW-1:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    freerun_go  = 1'b0;
    if (vreset_i) begin
      frame_cnt_d = '0;
    end else if (state_q == StWait && frame_end) begin
      if (frame_cnt_q == FrameW'(FREERUN_FRAMES - 1)) begin
        freerun_go  = 1'b1;
        frame_cnt_d = '0;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end
`else
  assign freerun_go = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StWait: begin
        if (vreset_i) begin
          state_d = StLocked;
        end else if (freerun_go) begin
          state_d = StFree;
        end
      end
      StFree: begin
        if (vreset_i) begin
          state_d = StLocked;
        end
      end
      StLocked: state_d = StLocked;
      default:  state_d = StWait;
    endcase
  end

  assign run = (state_q == StFree) || (state_q == StLocked);

  always_comb begin
    de_d   = run && (hcnt_ext < HActiveC) && (vcnt_ext < VActiveC);
    hs_n_d = !(run && (hcnt_ext >= HSyncStartC) && (hcnt_ext < HSyncEndC));
    vs_n_d = !(run && (vcnt_ext >= VSyncStartC) && (vcnt_ext < VSyncEndC));
    sof_d  = run && (hcnt_q == '0) && (vcnt_q == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StWait;
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      hs_n_q  <= 1'b1;
      vs_n_q  <= 1'b1;
      de_q    <= 1'b0;
      sof_q   <= 1'b0;
      hpos_q  <= '0;
      vpos_q  <= '0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      hs_n_q  <= hs_n_d;
      vs_n_q  <= vs_n_d;
      de_q    <= de_d;
      sof_q   <= sof_d;
      hpos_q  <= hcnt_q;
      vpos_q  <= vcnt_q;
    end
  end

  assign hs_n_o   = hs_n_q;
  assign vs_n_o   = vs_n_q;
  assign de_o     = de_q;
  assign sof_o    = sof_q;
  assign hpos_o   = hpos_q;
  assign vpos_o   = vpos_q;
  assign locked_o = (state_q == StLocked);

endmodule

// File: tb/tb_video_timing_gen.sv
// Scoreboard bench for video_timing_gen using a reduced raster so whole frames stay short.
module tb_video_timing_gen;

  localparam int HA = 16, HF = 2, HS = 4, HB = 3, HT = HA + HF + HS + HB;
  localparam int VA = 10, VF = 1, VS = 2, VB = 2, VT = VA + VF + VS + VB;
  localparam int RH = 3, RV = 1;
  localparam int FRAME = HT * VT;
  localparam int FR = 4;

  logic        clk, reset, vreset;
  logic        hs_n, vs_n, de, sof, locked;
  logic [11:0] hpos;
  logic [10:0] vpos;

  video_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .RESYNC_H(RH), .RESYNC_V(RV)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .vreset_i (vreset),
    .hs_n_o   (hs_n),
    .vs_n_o   (vs_n),
    .de_o     (de),
    .hpos_o   (hpos),
    .vpos_o   (vpos),
    .sof_o    (sof),
    .locked_o (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        hs_n, vs_n, de, sof, locked;
    logic [11:0] hpos;
    logic [10:0] vpos;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   m_h, m_v, m_st, m_fc;  // model: state 0 wait, 1 free, 2 locked
  int   obs_de, obs_sof, obs_hs, obs_vs;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 20) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_h = 0; m_v = 0; m_st = 0; m_fc = 0;
    sb_q.delete();
  endtask

  task automatic clr_obs();
    obs_de = 0; obs_sof = 0; obs_hs = 0; obs_vs = 0;
  endtask

  // Called at a falling edge: drives vreset, predicts the post-edge outputs, checks at edge+1.
  task automatic step(input logic vr);
    exp_t e, got_e;
    int   nst;
    bit   run;
    vreset = vr;
    run    = (m_st != 0);
    e.de   = run && m_h < HA && m_v < VA;
    e.hs_n = !(run && m_h >= HA + HF && m_h < HA + HF + HS);
    e.vs_n = !(run && m_v >= VA + VF && m_v < VA + VF + VS);
    e.sof  = run && m_h == 0 && m_v == 0;
    e.hpos = 12'(m_h);
    e.vpos = 11'(m_v);
    nst = m_st;
    if (vr) begin
      nst = 2; m_fc = 0;
    end
`ifdef VTG_FREERUN_EN
    else if (m_st == 0 && m_h == HT - 1 && m_v == VT - 1) begin
      m_fc++;
      if (m_fc == FR) begin
        nst = 1; m_fc = 0;
      end
    end
`endif
    e.locked = (nst == 2);
    if (vr) begin
      m_h = RH; m_v = RV;
    end else if (m_h == HT - 1) begin
      m_h = 0;
      m_v = (m_v == VT - 1) ? 0 : m_v + 1;
    end else begin
      m_h++;
    end
    m_st = nst;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got_e = sb_q.pop_front();
    check_eq("hs_n", hs_n, got_e.hs_n);
    check_eq("vs_n", vs_n, got_e.vs_n);
    check_eq("de", de, got_e.de);
    check_eq("sof", sof, got_e.sof);
    check_eq("locked", locked, got_e.locked);
    check_eq("hpos", hpos, got_e.hpos);
    check_eq("vpos", vpos, got_e.vpos);
    obs_de  += int'(de);
    obs_sof += int'(sof);
    obs_hs  += int'(!hs_n);
    obs_vs  += int'(!vs_n);
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_hs_n"}, hs_n, 1'b1);
    check_eq({tag, "_vs_n"}, vs_n, 1'b1);
    check_eq({tag, "_de"}, de, 1'b0);
    check_eq({tag, "_sof"}, sof, 1'b0);
    check_eq({tag, "_locked"}, locked, 1'b0);
    check_eq({tag, "_hpos"}, hpos, 12'd0);
    check_eq({tag, "_vpos"}, vpos, 11'd0);
  endtask

  task automatic run_until(input int h, input int v, input string tag);
    bit found = 0;
    for (int i = 0; i < 2 * FRAME; i++) begin
      if (m_h == h && m_v == v) begin
        found = 1;
        break;
      end
      step(1'b0);
    end
    check_eq(tag, found, 1'b1);
  endtask

  task automatic check_full_frame(input string tag);
    clr_obs();
    repeat (FRAME) step(1'b0);
    check_eq({tag, "_de_cnt"}, obs_de, HA * VA);
    check_eq({tag, "_sof_cnt"}, obs_sof, 1);
    check_eq({tag, "_hs_cnt"}, obs_hs, HS * VT);
    check_eq({tag, "_vs_cnt"}, obs_vs, VS * HT);
  endtask

  initial begin
    reset  = 1'b1;
    vreset = 1'b0;
    model_reset();
    #1;
    check_reset_outputs("rst");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Blank in WAIT for three frames.
    clr_obs();
    repeat (3 * FRAME) step(1'b0);
    check_eq("t1_de_cnt", obs_de, 0);
    check_eq("t1_hs_cnt", obs_hs, 0);
    check_eq("t1_vs_cnt", obs_vs, 0);
    check_eq("t1_sof_cnt", obs_sof, 0);

    // First lock, then a full steady frame.
    repeat (40) step(1'b0);
    step(1'b1);
    check_eq("t2_locked", locked, 1'b1);
    step(1'b0);
    check_eq("t2_hpos_reload", hpos, 12'(RH));
    check_eq("t2_vpos_reload", vpos, 11'(RV));
    check_full_frame("t2");

    // Mid-frame realign while locked.
    run_until(10, 5, "t3_reach");
    step(1'b1);
    step(1'b0);
    check_eq("t3_hpos", hpos, 12'(RH));
    check_eq("t3_vpos", vpos, 11'(RV));
    check_eq("t3_locked", locked, 1'b1);

    // vreset on the last pixel of the frame beats the wrap.
    run_until(HT - 1, VT - 1, "t4_reach");
    step(1'b1);
    step(1'b0);
    check_eq("t4_hpos", hpos, 12'(RH));
    check_eq("t4_vpos", vpos, 11'(RV));
    clr_obs();
    repeat (FRAME) step(1'b0);
    check_eq("t4_sof_cnt", obs_sof, 1);

`ifdef VTG_FREERUN_EN
    reset = 1'b1;
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    clr_obs();
    repeat (FR * FRAME) step(1'b0);
    check_eq("t5_wait_de", obs_de, 0);
    check_eq("t5_free_locked", locked, 1'b0);
    check_full_frame("t5");
    check_eq("t5_still_unlocked", locked, 1'b0);
    repeat (7) step(1'b0);
    step(1'b1);
    check_eq("t5_locked", locked, 1'b1);
`endif

    // Asynchronous reset in the middle of a locked frame.
    step(1'b1);
    run_until(8, 4, "t6_reach");
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("t6");
    @(negedge clk);
    model_reset();
    reset = 1'b0;
    clr_obs();
    repeat (FRAME) step(1'b0);
    check_eq("t6_wait_de", obs_de, 0);
    check_eq("t6_wait_locked", locked, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
